// File: rtl/mips_iter_divider.sv
// Restoring iterative divider for MIPS DIV/DIVU: one quotient bit per clock, quotient to LO, remainder to HI.
// Optional macro DIV_ZERO_DETECT_EN adds the div_zero port and a one-cycle shortcut for a zero divisor.
module mips_iter_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_DETECT_EN
    ,
    output logic             div_zero
`endif
);

    // Handshake: start is sampled only while busy=0 (IDLE). busy stays high from the
    // accepting edge until the result edge. done is a single-cycle pulse, and busy is
    // already low in that cycle, so a start in the done cycle is accepted back-to-back.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] pr_q;      // partial remainder (always below the divisor)
    logic [WIDTH-1:0] dq_q;      // dividend shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dv_q;      // divisor magnitude
    logic [CNT_W-1:0] count_q;
    logic             sign_q_q;
    logic             sign_r_q;
`ifdef DIV_ZERO_DETECT_EN
    logic             dz_q;
`endif

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

    assign busy = (state_q != IDLE);

    always_comb begin
        dvd_mag = dividend;
        dvs_mag = divisor;
        if (is_signed && dividend[WIDTH-1]) dvd_mag = -dividend;
        if (is_signed && divisor[WIDTH-1])  dvs_mag = -divisor;
        shifted = {pr_q, dq_q[WIDTH-1]};
        trial   = shifted - {1'b0, dv_q};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_DETECT_EN
                    state_d = (divisor == '0) ? FIX : CALC;
`else
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                if (count_q == CNT_W'(1)) state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_q      <= '0;
            dq_q      <= '0;
            dv_q      <= '0;
            count_q   <= '0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
            dz_q      <= 1'b0;
            div_zero  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dq_q     <= dvd_mag;
                        dv_q     <= dvs_mag;
                        pr_q     <= '0;
                        count_q  <= CNT_W'(WIDTH);
                        sign_q_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        sign_r_q <= is_signed & dividend[WIDTH-1];
`ifdef DIV_ZERO_DETECT_EN
                        // A zero divisor bypasses CALC; keep the raw dividend for the remainder.
                        dz_q     <= (divisor == '0);
                        div_zero <= 1'b0;
                        if (divisor == '0) dq_q <= dividend;
`endif
                    end
                end
                CALC: begin
                    // A set MSB in trial means the subtraction went negative: restore.
                    pr_q    <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    dq_q    <= {dq_q[WIDTH-2:0], ~trial[WIDTH]};
                    count_q <= count_q - CNT_W'(1);
                end
                FIX: begin
                    done <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
                    if (dz_q) begin
                        quotient  <= '1;
                        remainder <= dq_q;
                        div_zero  <= 1'b1;
                    end else begin
`else
                    begin
`endif
                        quotient  <= sign_q_q ? -dq_q : dq_q;
                        remainder <= sign_r_q ? -pr_q : pr_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_iter_divider.sv
// Self-checking bench for mips_iter_divider: directed table, handshake/reset sequences, random ops vs. arithmetic model.
module tb_mips_iter_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
`ifdef DIV_ZERO_DETECT_EN
    logic        div_zero;
`endif

    int errors = 0;
    int checks = 0;

    mips_iter_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV_ZERO_DETECT_EN
        ,
        .div_zero  (div_zero)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: MIPS division from plain 64-bit arithmetic (truncating, remainder follows dividend).
    function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
`ifdef DIV_ZERO_DETECT_EN
            q = 32'hFFFF_FFFF;
`else
            q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
`endif
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int ref_lat(input logic [31:0] b);
`ifdef DIV_ZERO_DETECT_EN
        return (b == 32'd0) ? 1 : 33;
`else
        return 33;
`endif
    endfunction

    // Driver: must be called away from a rising edge. Pulses start for one edge, scrambles
    // the operand inputs afterwards, then counts edges until done (bounded).
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic busy_ok);
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1;
        start     = 1'b0;
        is_signed = ~s;
        dividend  = $urandom;
        divisor   = $urandom;
        busy_ok   = busy;
        lat       = 0;
        forever begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            if (lat > 80) begin
                $display("FAIL timeout: no done after %0d cycles", lat);
                break;
            end
        end
        if (busy) busy_ok = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic s, input logic [31:0] a,
                            input logic [31:0] b);
        int          lat;
        logic        bok;
        logic [31:0] eq, er;
        ref_div(s, a, b, eq, er);
        run_op(s, a, b, lat, bok);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " latency"}, 32'(lat), 32'(ref_lat(b)));
        check({tag, " busy"}, {31'd0, bok}, 32'd1);
`ifdef DIV_ZERO_DETECT_EN
        check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, (b == 32'd0)});
`endif
    endtask

    initial begin
        int          n;
        int          lat;
        logic        bok;
        logic        seen;
        logic        s;
        logic [31:0] a, b;

        vecs.push_back('{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33});
        vecs.push_back('{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  33});
        vecs.push_back('{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          33});
        vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33});
        vecs.push_back('{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33});
        vecs.push_back('{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33});
`ifdef DIV_ZERO_DETECT_EN
        vecs.push_back('{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1});
        vecs.push_back('{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1});
`else
        vecs.push_back('{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          33});
        vecs.push_back('{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          33});
        vecs.push_back('{1'b1, 32'hFFFF_FFFB,  32'd0,          32'd1,          32'hFFFF_FFFB,  33});
`endif

        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].s, vecs[i].a, vecs[i].b, lat, bok);
            check($sformatf("vec%0d quotient", i), quotient, vecs[i].q);
            check($sformatf("vec%0d remainder", i), remainder, vecs[i].r);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d busy", i), {31'd0, bok}, 32'd1);
            @(negedge clk);
        end

        // done is one cycle wide and results hold afterwards
        run_op(1'b0, 32'd1000, 32'd3, lat, bok);
        @(posedge clk);
        #1;
        check("done pulse width", {31'd0, done}, 32'd0);
        check("hold quotient", quotient, 32'd333);
        check("hold remainder", remainder, 32'd1);
`ifdef DIV_ZERO_DETECT_EN
        run_op(1'b0, 32'd9, 32'd0, lat, bok);
        check("dz set", {31'd0, div_zero}, 32'd1);
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd9; divisor = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("dz hold until start", {31'd0, div_zero}, 32'd0);
        repeat (40) @(posedge clk);
`endif

        // start while busy is ignored
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b1; is_signed = 1'b1; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk);
        #1;
        n++;
        start = 1'b0;
        while (!done && n < 80) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ignored start latency", 32'(n), 32'd33);
        check("ignored start quotient", quotient, 32'd14);
        check("ignored start remainder", remainder, 32'd2);

        // back-to-back: issue in the done cycle
        check_op("b2b", 1'b1, 32'hFFFF_FF9C, 32'd7);

        // reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd12345; divisor = 32'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort quotient", quotient, 32'd0);
        check("abort remainder", remainder, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("abort no done", {31'd0, seen}, 32'd0);

        // random operations against the model, some issued back-to-back
        for (int k = 0; k < 40; k++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                3:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            check_op($sformatf("rnd%0d", k), s, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_iter_divider.md
Name: mips_iter_divider

Overview:
- Multi-cycle 32-bit integer divider for the MIPS core's DIV/DIVU instructions.
- Produces the quotient for LO and the remainder for HI.
- Restoring algorithm: one quotient bit per clock, each step a trial subtraction of the divisor from the partial remainder.
- Sits beside the ALU in EX. The pipeline stalls while busy is high and captures results on done.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- is_signed  input  1  1=DIV (two's complement), 0=DIVU; latched with start.
- dividend  input  WIDTH  numerator; latched with start.
- divisor  input  WIDTH  denominator; latched with start.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when quotient/remainder are valid.
- quotient  output  WIDTH  registered quotient (to LO).
- remainder  output  WIDTH  registered remainder (to HI).
- div_zero  output  1  present only with DIV_ZERO_DETECT_EN.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_zero=0; internal counter and registers cleared.
- Reset mid-operation aborts immediately. No done is produced for the aborted operation.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge E0 latches operands and is_signed.
  - Stores magnitudes: abs() when is_signed=1, raw values otherwise.
  - Records sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend). Both are 0 when unsigned.
  - Clears the WIDTH+1-bit partial remainder, loads count=WIDTH, goes to CALC with busy=1.
  - done is forced to 0 on every edge except the FIX edge.
- CALC, edges E1..E32:
  - Shift {partial remainder, dividend register} left by 1.
  - Compute trial = partial_rem − {0, divisor} at WIDTH+1 bits.
  - If trial is non-negative (MSB=0): partial_rem = trial and the new quotient LSB = 1. Otherwise restore and the LSB = 0.
  - count decrements; when count reaches 0 after this edge, go to FIX.
- FIX, edge E33:
  - quotient = sign_q ? −q : q; remainder = sign_r ? −r : r, all modulo 2^WIDTH.
  - done=1 and busy=0 for exactly the cycle after E33, then back to IDLE.
  - Total latency: start sampled at E0, done visible after E33 (33 cycles).
- start while busy=1 is ignored: no queuing, operands unchanged.
- start asserted in the cycle done is high is accepted, since busy=0 then (back-to-back issue).
- quotient/remainder hold their values until the next FIX edge or reset.
- Remainder sign always follows the dividend; the quotient truncates toward zero (MIPS semantics).
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0, no exception.
- Divide by zero without the macro: the full 33 cycles run.
  - Unsigned: quotient=0xFFFFFFFF, remainder=dividend.
  - Signed: quotient=0xFFFFFFFF if dividend≥0, else 0x00000001; remainder=dividend.

Optional Feature:
- Macro: DIV_ZERO_DETECT_EN.
- Defined:
  - div_zero port exists.
  - A start with divisor=0 skips CALC and goes IDLE→FIX directly, so done follows at E1.
  - Result is quotient=0xFFFFFFFF, remainder=dividend (unmodified), div_zero=1 alongside done.
  - div_zero holds until the next accepted start, which clears it; reset clears it.
- Undefined: no div_zero port; the divide-by-zero behaviour is as given under Behaviour.

Test Plan:
- Unsigned: dividend=100, divisor=7, is_signed=0 → done after 33 cycles, quotient=14, remainder=2; busy high cycles 1..33.
- Signed: dividend=−100 (0xFFFFFF9C), divisor=7 → quotient=0xFFFFFFF2 (−14), remainder=0xFFFFFFFE (−2). Then dividend=100, divisor=−7 → quotient=−14, remainder=2.
- Overflow and DIVU extreme:
  - 0x80000000 / 0xFFFFFFFF signed → quotient=0x80000000, remainder=0.
  - Same operands with is_signed=0 → quotient=0, remainder=0x80000000.
- Handshake:
  - Pulse start at cycle 5 with new operands → ignored, result still from the first operands.
  - start in the done cycle → second operation completes exactly 33 cycles later.
- Reset and divide-by-zero:
  - Drop rst_n at cycle 10 of an operation → busy/done/quotient/remainder are 0 immediately; no done follows.
  - 5/0 with the macro → done at cycle 1, quotient=0xFFFFFFFF, remainder=5, div_zero=1.
  - 5/0 without the macro → done at cycle 33 with the same values.
